// File: rtl/program_encoder.sv
`default_nettype none
// ============================================================================
// Module   : program_encoder
// Purpose  : Packs decoded ARMv4 instruction fields into 32-bit words and
//            writes them to consecutive instruction-memory word addresses.
//            Data-processing immediates may be given as a 32-bit constant.
//            The block then searches for the rot/imm8 encoding of that
//            constant.
// Ports    : clk, rst (async, active-high)
//            start, base_addr        - session control
//            in_valid/in_ready, in_* - instruction field handshake
//            mem_we/mem_ready, mem_addr, mem_wdata - ready-gated write port
//            busy, done, err, err_code, count     - status
// Revision : 1.0 - initial release
// ============================================================================
module program_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic [23:0]       in_imm24,
  input  logic              in_use_imm32,
  input  logic [31:0]       in_imm32,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_SEARCH = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [1:0] c_ERR_OP   = 2'b01;
  localparam logic [1:0] c_ERR_IMM  = 2'b10;
  localparam logic [1:0] c_ERR_ADDR = 2'b11;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic [31:0]       r_imm32;
  logic              r_last;
  logic [3:0]        r_rot;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_bad_op;
  logic              w_do_search;
  logic [5:0]        w_funct;
  logic [31:0]       w_pack;
  logic [63:0]       w_dbl;
  logic [31:0]       w_rol;
  logic              w_hit;
  logic              w_addr_max;

  // Branch form needs funct[5] set (B/BL); op 11 has no encoding here.
  assign w_bad_op    = (in_op == 2'b11) || ((in_op == 2'b10) && !in_funct[5]);
  assign w_do_search = in_use_imm32 && (in_op == 2'b00);
  // A searched constant always becomes an immediate operand, so force the I bit.
  assign w_funct     = w_do_search ? {1'b1, in_funct[4:0]} : in_funct;
  assign w_pack      = (in_op == 2'b10) ?
                       {in_cond, 2'b10, in_funct[5:4], in_imm24} :
                       {in_cond, in_op, w_funct, in_rn, in_rd, in_src2};

  // Rotate-left by 2r: the upper half of a doubled word shifted left.
  assign w_dbl      = {r_imm32, r_imm32} << {r_rot, 1'b0};
  assign w_rol      = w_dbl[63:32];
  assign w_hit      = (w_rol[31:8] == 24'd0);
  assign w_addr_max = &r_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ACCEPT;
      S_ACCEPT: begin
        if (in_valid) begin
          if (w_bad_op)         w_next = S_ERROR;
          else if (w_do_search) w_next = S_SEARCH;
          else                  w_next = S_WRITE;
        end
      end
      S_SEARCH: begin
        if (w_hit)                w_next = S_WRITE;
        else if (r_rot == 4'd15)  w_next = S_ERROR;
      end
      S_WRITE: begin
        if (mem_ready) begin
          if (r_last)          w_next = S_DONE;
          else if (w_addr_max) w_next = S_ERROR;
          else                 w_next = S_ACCEPT;
        end
      end
      S_DONE:   w_next = S_IDLE;
      S_ERROR:  if (start) w_next = S_ACCEPT;
      default:  w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (r_state == S_ACCEPT);
    mem_we   = (r_state == S_WRITE);
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_wdata    <= '0;
      r_imm32    <= '0;
      r_last     <= 1'b0;
      r_rot      <= 4'd0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            r_addr     <= base_addr;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            r_wdata <= w_pack;
            r_imm32 <= in_imm32;
            r_last  <= in_last;
            r_rot   <= 4'd0;
            if (w_bad_op) begin
              r_err      <= 1'b1;
              r_err_code <= c_ERR_OP;
            end
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_wdata[11:0] <= {r_rot, w_rol[7:0]};
          end else if (r_rot == 4'd15) begin
            r_err      <= 1'b1;
            r_err_code <= c_ERR_IMM;
          end else begin
            r_rot <= r_rot + 4'd1;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
            if (!r_last) begin
              if (w_addr_max) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_ADDR;
              end else begin
                r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: doc/program_encoder.md
# program_encoder

Field-level instruction encoder and program loader, the writer counterpart of the control-unit decoder. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit ARMv4 words using the same field layout the decoder slices. It can also search for the rotated-immediate encoding of a 32-bit constant. Each word is written to sequential instruction-memory addresses through a ready-gated write port. It sits between the test/boot host and instruction memory.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load session; ignored unless state is IDLE or ERROR
- base_addr  in  ADDR_W  first word address, sampled on start
- in_valid / in_ready  in / out  1  instruction handshake; transfer when both high
- in_cond  in  4  condition field, bits [31:28]
- in_op  in  2  op field, bits [27:26]
- in_funct  in  6  funct field, bits [25:20]
- in_rn, in_rd  in  4  bits [19:16], [15:12]
- in_src2  in  12  bits [11:0] verbatim (shamt5/sh/Rm, Rs form, rot/imm8, imm12)
- in_imm24  in  24  branch offset, bits [23:0]
- in_use_imm32  in  1  replace src2 with the searched encoding of in_imm32
- in_imm32  in  32  constant to encode
- in_last  in  1  final instruction of session
- mem_we  out  1  write request, held until mem_ready
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded word
- mem_ready  in  1  memory accepts write this cycle when mem_we high
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last write completes
- err  out  1  sticky error flag
- err_code  out  2  01 illegal op, 10 immediate not encodable, 11 address overflow
- count  out  ADDR_W+1  words written this session

## Operation
- States: IDLE, ACCEPT, SEARCH, WRITE, DONE, ERROR.
- IDLE, on start: latch base_addr into the address register, clear count, err, and err_code, go to ACCEPT.
- ACCEPT: in_ready=1. On transfer, latch all fields and check them in this order:
  - in_op=11, or in_op=10 with in_funct[5]=0: go to ERROR, code 01.
  - in_use_imm32=1 and in_op=00: set funct[5]=1, go to SEARCH.
  - Otherwise go to WRITE.
- Word packing:
  - op 00/01: {cond, op, funct, rn, rd, src2}.
  - op 10: {cond, 2'b10, funct[5:4], imm24}.
  - in_use_imm32 with op≠00 is ignored and src2 is used.
- SEARCH: rotation counter r runs 0..15, one value per cycle. Hit when rol(imm32, 2r)[31:8]==0. On a hit, src2={r[3:0], rol(imm32,2r)[7:0]} and the state goes to WRITE. The lowest r always wins. No hit at r=15: go to ERROR, code 10.
- WRITE: mem_we=1, with mem_addr and mem_wdata held stable until mem_ready. On the accepting cycle:
  - count increments.
  - If in_last was latched, go to DONE.
  - Else if mem_addr is all-ones, go to ERROR, code 11. No wrap to 0.
  - Else mem_addr increments and the state returns to ACCEPT.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: in_ready=0, mem_we=0, err=1 and err_code held. Only start (restarts the session) or rst leaves this state.
- start in ACCEPT, SEARCH, WRITE or DONE is ignored.

## Timing
- Reset, asynchronous: state IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr, mem_wdata, err_code, count = 0.
- Plain instruction: handshake in cycle T, mem_we high from T+1.
- Searched immediate: SEARCH occupies cycles T+1..T+1+r. mem_we rises at T+2+r, so worst case (r=15) is T+17.
- A write accepted in cycle W returns to ACCEPT, with in_ready high at W+1. Throughput is one word per 2 cycles at best.
- done pulses the cycle after the last write is accepted; busy falls the cycle after that.
- mem_ready while mem_we=0 has no effect. mem_ready held low stalls WRITE indefinitely.
- Reset asserted mid-session aborts immediately. Any pending write is dropped and no partial state survives.

## Test plan
- Reset then start with base 0x10. Send ADD: cond E, op 00, funct 001000, rn 1, rd 2, src2 0x003. Expect one write of 0xE0812003 at 0x10, done pulse, count=1.
- Branch-with-link: cond E, op 10, funct 11xxxx, imm24 0x000004. Expect 0xEB000004. Separately send op 11; expect err=1, code 01, no mem_we.
- Immediates, each checked against its SEARCH cycle count:
  - imm32 0xFF000000: src2 0x4FF after 5 SEARCH cycles.
  - imm32 0x000003FC: src2 0xFFF after 16 SEARCH cycles.
  - imm32 0x00000102: err code 10.
- 3-instruction session with mem_ready held low 4 cycles on the second write. Expect mem_addr and mem_wdata stable throughout, addresses base, base+1, base+2, done after the third.
- base 0xFE with 3 instructions, last on the third. Expect writes at 0xFE and 0xFF, then ERROR code 11 and count=2. A following start recovers the block.
- Assert rst during SEARCH. Expect all outputs at reset values immediately; the next start session completes normally.
